mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: STAGES, default 4, multiplier pipeline latency in cycles from issue to result.
REQ-002 Parameter: XLEN, default 32, operand and result width.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 req_valid_i  input  2  per-requester request valid (index 0, 1).
REQ-006 req_ready_o  output  2  per-requester grant; handshake completes when valid && ready.
REQ-007 req_op_i  input  2x2  per-requester op: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-008 req_a_i, req_b_i  input  2xXLEN  per-requester operands rs1, rs2.
REQ-009 mul_valid_o  output  1  issue strobe to multiplier opcode_valid.
REQ-010 mul_opcode_o  output  32  R-type word: funct7 0000001, rs2/rs1 fields 0, funct3 {0,op}, rd 0, opcode 0110011.
REQ-011 mul_ra_o, mul_rb_o  output  XLEN  operands of the granted request.
REQ-012 mul_hold_o  output  1  freezes multiplier pipeline.
REQ-013 mul_result_i  input  XLEN  multiplier writeback value.
REQ-014 rsp_valid_o, rsp_ready_i  output/input  1  response handshake.
REQ-015 rsp_id_o  output  1  requester index of the response.
REQ-016 rsp_data_o  output  XLEN  result; equals mul_result_i.
REQ-017 busy_o  output  1  high when any operation is in flight.

Function
REQ-018 Round-robin arbitration: pointer names the preferred requester; the other is granted only if the preferred is not valid.
REQ-019 Pointer moves to the non-granted requester after every accepted request; unchanged on idle cycles.
REQ-020 At most one bit of req_ready_o high per cycle; req_ready_o = 0 whenever mul_hold_o = 1.
REQ-021 req_ready_o shall depend on req_valid_i, pointer, and hold only; requesters shall not condition valid on ready.
REQ-022 mul_valid_o = 1 exactly in cycles with an accepted request; mul_opcode_o/ra/rb carry that request's op and operands.
REQ-023 Tag pipeline of STAGES slots (valid, id) advances one slot per cycle when mul_hold_o = 0; frozen otherwise.
REQ-024 Request accepted in cycle t produces rsp_valid_o = 1 in cycle t+STAGES absent hold; each hold cycle adds one cycle.
REQ-025 rsp_valid_o = last-slot valid; rsp_id_o = last-slot id.
REQ-026 mul_hold_o = rsp_valid_o && !rsp_ready_i (combinational).
REQ-027 While held, rsp_valid_o, rsp_id_o, rsp_data_o remain stable until accepted.
REQ-028 Responses return in issue order; throughput one per cycle with rsp_ready_i held high.
REQ-029 busy_o = OR of all tag valid bits.
REQ-030 Boundary: both requesters valid every cycle -> grants strictly alternate; no starvation.
REQ-031 Boundary: response accepted and new request issued in the same cycle -> both occur; pipeline stays full.

Reset
REQ-032 rst_ni low at a rising edge clears all tag valids and sets pointer to requester 0; in-flight operations are discarded, never returned.
REQ-033 During and one cycle after reset: rsp_valid_o, mul_valid_o, mul_hold_o, busy_o, req_ready_o = 0; data outputs = 0.

Structure
REQ-034 Package mul_arb_pkg: op enum (MUL, MULH, MULHSU, MULHU), FUNCT7_MULDIV, OPCODE_OP, default STAGES.
REQ-035 Sub-module mul_tag_pipe: STAGES-deep (valid, id) shift register with advance enable and synchronous clear.

Verification
REQ-036 Req0 MUL a=9 b=7 accepted cycle t -> rsp_valid_o at t+4, rsp_id_o 0, rsp_data_o 0x0000003F.
REQ-037 Both requesters valid 8 cycles, rsp_ready_i=1 -> grants 0,1,0,1,...; 8 responses back-to-back, same id order.
REQ-038 Pipeline full, rsp_ready_i low 3 cycles -> mul_hold_o high 3 cycles, req_ready_o 00, rsp_data_o stable, no response lost or duplicated.
REQ-039 a=b=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF; MUL -> 0x00000001.
REQ-040 Three ops in flight, rst_ni low one cycle -> no rsp_valid_o afterwards, busy_o 0, next simultaneous request granted to requester 0.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the two-port multiplier arbiter.
//   mul_op_e      : requester op encoding (MUL, MULH, MULHSU, MULHU)
//   tag_t         : in-flight tag carried alongside the multiplier pipeline
//   mul_opcode()  : builds the R-type instruction word for an op
package mul_arb_pkg;

    localparam int unsigned STAGES_DEFAULT = 4;
    localparam int unsigned XLEN_DEFAULT   = 32;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    // R-type word with rs1/rs2/rd fields zeroed; funct3 = {0, op}
    function automatic logic [31:0] mul_opcode(input mul_op_e op);
        return {FUNCT7_MULDIV, 5'd0, 5'd0, 1'b0, 2'(op), 5'd0, OPCODE_OP};
    endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Bus bundle between two requesters, the arbiter, the multiplier and the
// response consumer. Signal names carry the arbiter's point of view (_i in,
// _o out).
//   slave  : arbiter side
//   master : environment side (requesters, multiplier, response sink)
interface mul_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic [1:0]            req_valid_i;
    logic [1:0]            req_ready_o;
    logic [1:0][1:0]       req_op_i;
    logic [1:0][XLEN-1:0]  req_a_i;
    logic [1:0][XLEN-1:0]  req_b_i;

    logic                  mul_valid_o;
    logic [31:0]           mul_opcode_o;
    logic [XLEN-1:0]       mul_ra_o;
    logic [XLEN-1:0]       mul_rb_o;
    logic                  mul_hold_o;
    logic [XLEN-1:0]       mul_result_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic                  rsp_id_o;
    logic [XLEN-1:0]       rsp_data_o;

    logic                  busy_o;

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, mul_result_i, rsp_ready_i,
        output req_ready_o, mul_valid_o, mul_opcode_o, mul_ra_o, mul_rb_o,
               mul_hold_o, rsp_valid_o, rsp_id_o, rsp_data_o, busy_o
    );

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, mul_result_i, rsp_ready_i,
        input  req_ready_o, mul_valid_o, mul_opcode_o, mul_ra_o, mul_rb_o,
               mul_hold_o, rsp_valid_o, rsp_id_o, rsp_data_o, busy_o
    );

endinterface

// File: rtl/mul_tag_pipe.sv
// STAGES-deep (valid, id) shift register that tracks which requester owns
// each multiplier pipeline slot.
//   i_clk   : clock
//   i_clr   : synchronous clear of all slots (wins over advance)
//   i_adv   : shift one slot; slots hold when low
//   i_tag   : tag entering slot 0
//   o_last  : tag in the final slot (registered)
//   o_any_c : OR of all slot valids (combinational)
module mul_tag_pipe
    import mul_arb_pkg::*;
#(
    parameter int unsigned STAGES = STAGES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_adv,
    input  tag_t i_tag,
    output tag_t o_last,
    output logic o_any_c
);

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_id;

    // Bit 0 is the newest slot; shifting left ages every slot together
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_valid <= '0;
            r_id    <= '0;
        end else if (i_adv) begin
            r_valid <= (r_valid << 1) | STAGES'(i_tag.valid);
            r_id    <= (r_id << 1)    | STAGES'(i_tag.id);
        end
    end

    assign o_last  = '{valid: r_valid[STAGES-1], id: r_id[STAGES-1]};
    assign o_any_c = |r_valid;

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between two
// requesters, returning results in issue order with backpressure.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   bus    : requester, multiplier and response signals (slave side)
//            req_*  - per-requester valid/ready, op, operands
//            mul_*  - issue strobe, opcode, operands, hold, result
//            rsp_*  - response valid/ready, requester id, data
//            busy_o - any operation in flight
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned STAGES = STAGES_DEFAULT,
    parameter int unsigned XLEN   = XLEN_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mul_arbiter_if.slave  bus
);

    logic            r_ptr;
    logic            r_init;

    logic            w_gate;
    logic            w_rsp_valid;
    logic            w_hold;
    logic            w_accept;
    logic            w_gnt_id;
    mul_op_e         w_op;
    logic [XLEN-1:0] w_ra;
    logic [XLEN-1:0] w_rb;
    tag_t            w_new_tag;
    tag_t            w_last;
    logic            w_any;

    // Pointer names the preferred requester; r_init marks the first cycle after reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ptr  <= 1'b0;
            r_init <= 1'b1;
        end else begin
            r_init <= 1'b0;
            if (w_accept) begin
                r_ptr <= ~w_gnt_id;
            end
        end
    end

    // All outputs stay quiet while reset is low and for one cycle after
    assign w_gate      = rst_ni & ~r_init;
    assign w_rsp_valid = w_gate & w_last.valid;
    assign w_hold      = w_rsp_valid & ~bus.rsp_ready_i;

    // Grant the preferred requester, else the other; nothing while held
    always_comb begin
        w_accept = 1'b0;
        w_gnt_id = r_ptr;
        if (w_gate && !w_hold) begin
            if (bus.req_valid_i[r_ptr]) begin
                w_accept = 1'b1;
            end else if (bus.req_valid_i[~r_ptr]) begin
                w_accept = 1'b1;
                w_gnt_id = ~r_ptr;
            end
        end
    end

    assign w_op = mul_op_e'(bus.req_op_i[w_gnt_id]);
    assign w_ra = w_accept ? bus.req_a_i[w_gnt_id] : '0;
    assign w_rb = w_accept ? bus.req_b_i[w_gnt_id] : '0;

    assign bus.req_ready_o  = w_accept ? (2'b01 << w_gnt_id) : 2'b00;
    assign bus.mul_valid_o  = w_accept;
    assign bus.mul_opcode_o = w_accept ? mul_opcode(w_op) : 32'd0;
    assign bus.mul_ra_o     = w_ra;
    assign bus.mul_rb_o     = w_rb;
    assign bus.mul_hold_o   = w_hold;

    assign w_new_tag = '{valid: w_accept, id: w_gnt_id};

    // Tags mirror the multiplier pipeline and freeze with it
    mul_tag_pipe #(
        .STAGES (STAGES)
    ) u_tag_pipe (
        .i_clk   (clk_i),
        .i_clr   (~rst_ni),
        .i_adv   (~w_hold),
        .i_tag   (w_new_tag),
        .o_last  (w_last),
        .o_any_c (w_any)
    );

    assign bus.rsp_valid_o = w_rsp_valid;
    assign bus.rsp_id_o    = w_gate & w_last.id;
    assign bus.rsp_data_o  = w_gate ? bus.mul_result_i : '0;
    assign bus.busy_o      = w_gate & w_any;

endmodule

// File: tb/tb_mul_arbiter.sv
// Randomized bench for mul_arbiter: a pipelined multiplier stub feeds the
// DUT, and a queue-based model of in-flight requests predicts every output.
module tb_mul_arbiter;
    import mul_arb_pkg::*;

    localparam int unsigned STAGES = STAGES_DEFAULT;
    localparam int unsigned XLEN   = 32;

    logic clk = 1'b1;
    logic rst_n;
    always #5 clk = ~clk;

    mul_arbiter_if #(.XLEN(XLEN)) bus ();

    mul_arbiter #(.STAGES(STAGES), .XLEN(XLEN)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Architectural multiply result from op and operands
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Multiplier stub: STAGES-cycle latency, frozen by mul_hold_o
    logic [STAGES-1:0][XLEN-1:0] stub_q;
    always @(posedge clk) begin
        if (!bus.mul_hold_o) begin
            stub_q <= {stub_q[STAGES-2:0],
                       bus.mul_valid_o ? ref_mul(bus.mul_opcode_o[13:12], bus.mul_ra_o, bus.mul_rb_o)
                                       : 32'd0};
        end
    end
    assign bus.mul_result_i = stub_q[STAGES-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester pending state
    logic [1:0]  pv;
    logic [1:0]  pop [2];
    logic [31:0] pa  [2];
    logic [31:0] pb  [2];
    logic        rdy;

    // Reference model: in-flight requests with their age in unheld cycles
    typedef struct {
        logic        id;
        logic [31:0] data;
        int          age;
    } ent_t;
    ent_t q[$];
    logic ptr;
    logic post_rst;
    int   cyc;

    // Observations from the most recent step
    logic        obs_rv;
    logic        obs_id;
    logic [31:0] obs_data;
    logic        obs_hold;
    logic [1:0]  obs_ready;
    logic        obs_busy;
    logic [31:0] log_d[$];
    logic        log_i[$];

    task automatic set_req(input int r, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        pv[r]  = 1'b1;
        pop[r] = op;
        pa[r]  = a;
        pb[r]  = b;
    endtask

    function automatic logic [31:0] rand_opnd();
        return ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
    endfunction

    // One clock cycle: drive, check at negedge, update model at posedge
    task automatic step();
        logic gate, e_rv, e_hold, e_acc, e_id, e_busy;
        bus.req_valid_i = pv;
        bus.req_op_i    = {pop[1], pop[0]};
        bus.req_a_i     = {pa[1], pa[0]};
        bus.req_b_i     = {pb[1], pb[0]};
        bus.rsp_ready_i = rdy;
        @(negedge clk);
        gate   = rst_n && !post_rst;
        e_rv   = gate && q.size() > 0 && q[0].age >= int'(STAGES);
        e_hold = e_rv && !rdy;
        e_busy = gate && q.size() > 0;
        e_acc  = 1'b0;
        e_id   = ptr;
        if (gate && !e_hold) begin
            if (pv[ptr]) e_acc = 1'b1;
            else if (pv[!ptr]) begin
                e_acc = 1'b1;
                e_id  = !ptr;
            end
        end
        check("req_ready", 64'(bus.req_ready_o), 64'(e_acc ? (e_id ? 2'b10 : 2'b01) : 2'b00));
        check("mul_valid", 64'(bus.mul_valid_o), 64'(e_acc));
        check("mul_hold",  64'(bus.mul_hold_o),  64'(e_hold));
        check("rsp_valid", 64'(bus.rsp_valid_o), 64'(e_rv));
        check("busy",      64'(bus.busy_o),      64'(e_busy));
        if (e_acc) begin
            check("opcode", 64'(bus.mul_opcode_o),
                  64'({7'h01, 5'd0, 5'd0, 1'b0, pop[e_id], 5'd0, 7'h33}));
            check("mul_ra", 64'(bus.mul_ra_o), 64'(pa[e_id]));
            check("mul_rb", 64'(bus.mul_rb_o), 64'(pb[e_id]));
        end
        if (e_rv) begin
            check("rsp_id",   64'(bus.rsp_id_o),   64'(q[0].id));
            check("rsp_data", 64'(bus.rsp_data_o), 64'(q[0].data));
        end
        if (!gate) begin
            check("rst_rsp_data", 64'(bus.rsp_data_o), 64'd0);
            check("rst_mul_ops", {bus.mul_ra_o, bus.mul_rb_o}, 64'd0);
            check("rst_opcode_id", 64'({bus.mul_opcode_o, bus.rsp_id_o}), 64'd0);
        end
        obs_rv    = bus.rsp_valid_o;
        obs_id    = bus.rsp_id_o;
        obs_data  = bus.rsp_data_o;
        obs_hold  = bus.mul_hold_o;
        obs_ready = bus.req_ready_o;
        obs_busy  = bus.busy_o;
        if (obs_rv && rdy) begin
            log_d.push_back(obs_data);
            log_i.push_back(obs_id);
        end
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            ptr      = 1'b0;
            post_rst = 1'b1;
        end else begin
            post_rst = 1'b0;
            if (e_rv && rdy) void'(q.pop_front());
            if (!e_hold) begin
                foreach (q[i]) q[i].age = q[i].age + 1;
            end
            if (e_acc) begin
                q.push_back('{id: e_id, data: ref_mul(pop[e_id], pa[e_id], pb[e_id]), age: 1});
                ptr      = !e_id;
                pv[e_id] = 1'b0;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp39 [4];
        logic [1:0]  op39  [4];
        logic        got;
        logic        start;
        int          issued;
        logic [31:0] held;

        pv = 2'b00; rdy = 1'b1; rst_n = 1'b0;
        ptr = 1'b0; post_rst = 1'b0; cyc = 0;
        for (int r = 0; r < 2; r++) begin
            pop[r] = 2'b00; pa[r] = 32'd0; pb[r] = 32'd0;
        end

        // Reset, with a request already waiting in the cycle after reset
        step();
        step();
        set_req(0, OP_MUL, 32'd9, 32'd7);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 64'(obs_ready), 64'd0);

        // Single MUL 9*7: four-cycle latency
        step();
        check("r036_accept", 64'(obs_ready), 64'(2'b01));
        got = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (obs_rv && !got) begin
                got = 1'b1;
                check("r036_latency", 64'(k), 64'd4);
                check("r036_id", 64'(obs_id), 64'd0);
                check("r036_data", 64'(obs_data), 64'h3F);
            end
        end
        if (!got) check("r036_seen", 64'd0, 64'd1);

        // All-ones operands through every op
        op39[0] = OP_MUL;    exp39[0] = 32'h0000_0001;
        op39[1] = OP_MULH;   exp39[1] = 32'h0000_0000;
        op39[2] = OP_MULHSU; exp39[2] = 32'hFFFF_FFFF;
        op39[3] = OP_MULHU;  exp39[3] = 32'hFFFF_FFFE;
        log_d.delete(); log_i.delete();
        for (int k = 0; k < 4; k++) begin
            set_req(0, op39[k], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            step();
        end
        for (int k = 0; k < 8; k++) step();
        check("r039_count", 64'(log_d.size()), 64'd4);
        for (int k = 0; k < 4 && k < log_d.size(); k++)
            check("r039_data", 64'(log_d[k]), 64'(exp39[k]));

        // Both requesters valid for 8 grants: strict alternation
        log_d.delete(); log_i.delete();
        start = ptr;
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < 2; r++)
                if (!pv[r]) set_req(r, 2'($urandom_range(0, 3)), rand_opnd(), rand_opnd());
            step();
            check("r037_grant", 64'(obs_ready), 64'((start ^ k[0]) ? 2'b10 : 2'b01));
        end
        pv = 2'b00;
        for (int k = 0; k < 8; k++) step();
        check("r037_count", 64'(log_i.size()), 64'd8);
        for (int k = 0; k < 8 && k < log_i.size(); k++)
            check("r037_order", 64'(log_i[k]), 64'(start ^ k[0]));

        // Full pipeline, three cycles of backpressure
        log_d.delete(); log_i.delete();
        issued = 0;
        for (int k = 0; k < 9; k++) begin
            for (int r = 0; r < 2; r++)
                if (!pv[r]) set_req(r, 2'($urandom_range(0, 3)), rand_opnd(), rand_opnd());
            rdy = (k < 6);
            step();
            if (obs_ready != 2'b00) issued++;
            if (k == 6) held = obs_data;
            if (k >= 6) begin
                check("r038_hold", 64'(obs_hold), 64'd1);
                check("r038_ready", 64'(obs_ready), 64'd0);
                check("r038_stable", 64'(obs_data), 64'(held));
            end
        end
        rdy = 1'b1;
        pv  = 2'b00;
        for (int k = 0; k < 10; k++) step();
        check("r038_no_loss", 64'(log_d.size()), 64'(issued));
        check("r038_idle", 64'(obs_busy), 64'd0);

        // Reset with three operations in flight
        for (int k = 0; k < 3; k++) begin
            set_req(k % 2, OP_MULHU, rand_opnd(), rand_opnd());
            step();
        end
        pv    = 2'b00;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("r040_no_rsp", 64'(obs_rv), 64'd0);
            check("r040_busy", 64'(obs_busy), 64'd0);
        end
        set_req(0, OP_MUL, rand_opnd(), rand_opnd());
        set_req(1, OP_MUL, rand_opnd(), rand_opnd());
        step();
        check("r040_grant0", 64'(obs_ready), 64'(2'b01));

        // Random traffic with random backpressure and rare resets
        for (int k = 0; k < 500; k++) begin
            for (int r = 0; r < 2; r++)
                if (!pv[r] && $urandom_range(0, 2) != 0)
                    set_req(r, 2'($urandom_range(0, 3)), rand_opnd(), rand_opnd());
            rdy   = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        rdy   = 1'b1;
        pv    = 2'b00;
        for (int k = 0; k < 12; k++) step();
        check("final_idle", 64'(obs_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
